// File: rtl/sample_streamer_if.sv
// ---------------------------------------------------------------------------
// sample_streamer_if
// Bundles the control handshake, data-memory read port and serial DAC pins
// of sample_streamer.
//   start      : single-cycle request to stream a buffer
//   base_addr  : word address of the first buffer word (sampled on accept)
//   length     : number of 32-bit words to stream (sampled on accept)
//   busy/done  : activity level and one-cycle completion pulse
//   mem_rd     : data-memory read strobe, mem_addr valid while high
//   mem_rdata  : read data, valid exactly one cycle after mem_rd
//   sclk/lrclk/sdata : serial bit clock, channel select (0=L,1=R), data MSB first
// Modports: slave = the streamer, master = the controller/memory side.
// ---------------------------------------------------------------------------
interface sample_streamer_if #(
  parameter int LEN_W = 16
);
  logic             start;
  logic [31:0]      base_addr;
  logic [LEN_W-1:0] length;
  logic             busy;
  logic             done;
  logic             mem_rd;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_rdata;
  logic             sclk;
  logic             lrclk;
  logic             sdata;

  modport slave (
    input  start, base_addr, length, mem_rdata,
    output busy, done, mem_rd, mem_addr, sclk, lrclk, sdata
  );

  modport master (
    output start, base_addr, length, mem_rdata,
    input  busy, done, mem_rd, mem_addr, sclk, lrclk, sdata
  );
endinterface

// File: rtl/sample_streamer.sv
// ---------------------------------------------------------------------------
// sample_streamer
// Reads a buffer of processed stereo samples (left in [31:16], right in
// [15:0]) from data memory and shifts it out to a DAC as a continuous serial
// stream: 32 bit periods per word, left half with lrclk=0, right half with
// lrclk=1. The next word is prefetched into a holding register while the
// current one shifts, so consecutive words follow with no gap bit.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : sample_streamer_if.slave (handshake, memory port, serial pins)
// Parameters:
//   CLK_DIV : clk cycles per sclk half-period (2..255)
//   LEN_W   : width of the word-count port and counter
// ---------------------------------------------------------------------------
module sample_streamer #(
  parameter int CLK_DIV = 4,
  parameter int LEN_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  sample_streamer_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    STREAM,
    FINISH
  } state_t;

  // Bit-period divider: sclk low while the count is below CLK_DIV, high above.
  localparam logic [8:0]       DIV_HALF = 9'(CLK_DIV - 1);
  localparam logic [8:0]       DIV_LAST = 9'(2 * CLK_DIV - 1);
  localparam logic [LEN_W-1:0] ONE_W    = LEN_W'(1);

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_mem_rd;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_next_addr;   // address of the next word still to fetch
  logic [LEN_W-1:0] r_words_left;  // words not yet fetched
  logic [31:0]      r_shift;       // bit 31 drives sdata
  logic [31:0]      r_hold;
  logic             r_hold_valid;
  logic             r_cap;         // prefetch data arrives this cycle
  logic [8:0]       r_div_cnt;
  logic [4:0]       r_bit_cnt;
  logic             r_sclk;
  logic             r_lrclk;

  logic w_prefetch;
  logic w_period_end;

  // A prefetch is started only when nothing is held or in flight and the
  // buffer still has unfetched words, so reads never run past the end.
  assign w_prefetch   = !r_hold_valid && !r_mem_rd && !r_cap && (r_words_left != '0);
  assign w_period_end = (r_div_cnt == DIV_LAST);

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.mem_rd   = r_mem_rd;
  assign bus.mem_addr = r_mem_addr;
  assign bus.sclk     = r_sclk;
  assign bus.lrclk    = r_lrclk;
  assign bus.sdata    = r_shift[31];

  // NOTE: every register here is assigned with <= so all updates in a cycle
  // see the same pre-edge values; the word-end branch is written after the
  // prefetch logic so its r_hold_valid clear takes precedence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_mem_addr   <= '0;
      r_next_addr  <= '0;
      r_words_left <= '0;
      r_shift      <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_cap        <= 1'b0;
      r_div_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_sclk       <= 1'b0;
      r_lrclk      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            if (bus.length == '0) begin
              r_state <= FINISH;
              r_done  <= 1'b1;
            end else begin
              r_state      <= FETCH;
              r_busy       <= 1'b1;
              r_mem_rd     <= 1'b1;
              r_mem_addr   <= bus.base_addr;
              r_next_addr  <= bus.base_addr + 32'd1;
              r_words_left <= bus.length - ONE_W;
            end
          end
        end

        FETCH: begin
          r_mem_rd <= 1'b0;
          r_state  <= LOAD;
        end

        LOAD: begin
          r_shift   <= bus.mem_rdata;
          r_lrclk   <= 1'b0;
          r_sclk    <= 1'b0;
          r_div_cnt <= '0;
          r_bit_cnt <= '0;
          r_state   <= STREAM;
        end

        STREAM: begin
          // Prefetch pipeline: strobe for one cycle, capture the cycle after.
          if (r_mem_rd) begin
            r_mem_rd <= 1'b0;
            r_cap    <= 1'b1;
          end else if (w_prefetch) begin
            r_mem_rd     <= 1'b1;
            r_mem_addr   <= r_next_addr;
            r_next_addr  <= r_next_addr + 32'd1;
            r_words_left <= r_words_left - ONE_W;
          end
          if (r_cap) begin
            r_hold       <= bus.mem_rdata;
            r_hold_valid <= 1'b1;
            r_cap        <= 1'b0;
          end

          // Bit timing: data and lrclk only move on the falling sclk edge.
          if (r_div_cnt == DIV_HALF) begin
            r_sclk <= 1'b1;
          end
          if (w_period_end) begin
            r_div_cnt <= '0;
            r_sclk    <= 1'b0;
            if (r_bit_cnt == 5'd31) begin
              if (r_hold_valid) begin
                r_shift      <= r_hold;
                r_lrclk      <= 1'b0;
                r_bit_cnt    <= '0;
                r_hold_valid <= 1'b0;
              end else begin
                r_state <= FINISH;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_shift <= '0;
                r_lrclk <= 1'b0;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
              r_shift   <= {r_shift[30:0], 1'b0};
              if (r_bit_cnt == 5'd15) begin
                r_lrclk <= 1'b1;
              end
            end
          end else begin
            r_div_cnt <= r_div_cnt + 9'd1;
          end
        end

        FINISH: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sample_streamer.md
SAMPLE_STREAMER -- requirements
Module: sample_streamer

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per sclk half-period; legal range 2..255.
REQ-002 Parameter LEN_W, default 16: width of the length port.
REQ-003 Port clk  in  1  system clock; all state updates on its rising edge.
REQ-004 Port rst  in  1  reset, asynchronous, active-low (rst=0 resets).
REQ-005 Port start  in  1  single-cycle request to begin streaming a buffer.
REQ-006 Port base_addr  in  32  word address of the first buffer word, sampled on an accepted start.
REQ-007 Port length  in  LEN_W  number of 32-bit words to stream, sampled on an accepted start.
REQ-008 Port mem_rd  out  1  data-memory read strobe.
REQ-009 Port mem_addr  out  32  data-memory word address, valid while mem_rd=1.
REQ-010 Port mem_rdata  in  32  read data, valid exactly one cycle after mem_rd=1.
REQ-011 Port busy  out  1  high from the cycle after an accepted start until done.
REQ-012 Port done  out  1  one-cycle completion pulse.
REQ-013 Port sclk  out  1  serial bit clock to the DAC.
REQ-014 Port lrclk  out  1  channel select: 0 = left, 1 = right.
REQ-015 Port sdata  out  1  serial sample data, MSB first.

Function
REQ-016 The block shall be the reader of the processor's processed-sample buffer: each word holds left sample in [31:16] and right sample in [15:0].
REQ-017 The FSM shall have states IDLE, FETCH, LOAD, STREAM, FINISH.
REQ-018 start shall be accepted only in IDLE; start while busy=1 shall be ignored.
REQ-019 Accepted start with length=0: IDLE -> FINISH, no mem_rd, done pulses the following cycle.
REQ-020 Accepted start with length>0: FETCH, mem_rd=1 for one cycle with mem_addr=base_addr; LOAD captures mem_rdata into the shift register; then STREAM.
REQ-021 Word address shall increment by 1 per word, modulo 2^32 (wrap from 0xFFFFFFFF to 0).
REQ-022 During STREAM the block shall prefetch the next word (one mem_rd pulse) into a holding register with a valid flag, issued within 4 cycles of the shift-register load, only if words remain.
REQ-023 Bit period = 2*CLK_DIV cycles: sclk=0 for the first CLK_DIV cycles, 1 for the second; sdata and lrclk change only while sclk falls/is low.
REQ-024 Each word shall take 32 bit periods: bits 31..16 with lrclk=0, then bits 15..0 with lrclk=1.
REQ-025 At the end of a word's 32nd bit period, if the holding register is valid it shall transfer to the shift register with no gap bit; the holding valid flag clears.
REQ-026 After the last word's 32nd bit period: FINISH, done=1 for exactly one cycle, busy=0 same cycle, then IDLE.
REQ-027 In IDLE and FINISH: sclk=0, lrclk=0, sdata=0, mem_rd=0.
REQ-028 Word counter shall be LEN_W bits; length=2^LEN_W-1 shall stream exactly that many words.
REQ-029 mem_rd shall never be asserted for an address beyond base_addr+length-1 (modulo 2^32).

Reset
REQ-030 rst=0 shall immediately, regardless of state (including mid-word), force IDLE and busy=0, done=0, mem_rd=0, mem_addr=0, sclk=0, lrclk=0, sdata=0, counters and holding valid flag cleared.
REQ-031 After rst returns to 1 the block shall accept start on the first clock edge.

Verification
REQ-032 CLK_DIV=4, start, base=0x10, length=1, mem[0x10]=0xA5A5_3C3C -> one mem_rd at 0x10; sdata bits 1010010110100101 with lrclk=0 then 0011110000111100 with lrclk=1; 256 sclk-active cycles; single done pulse.
REQ-033 length=3, base=0xFFFFFFFF -> mem_rd addresses 0xFFFFFFFF, 0x0, 0x1 in order; 96 contiguous bit periods with no idle gap between words.
REQ-034 length=0 -> no mem_rd, done pulses the cycle after the start cycle, sclk stays 0.
REQ-035 start re-asserted mid-stream with different base/length -> ignored; original buffer completes unchanged.
REQ-036 rst=0 asserted during bit 20 of word 2 of 4 -> all outputs 0 asynchronously; subsequent start with length=1 streams correctly.
REQ-037 Checker on all runs: sdata/lrclk stable while sclk=1; done never high while busy=1; mem_rd count equals length.
